// File: rtl/pulse_train_tx_pkg.sv
// Shared types and defaults for the pulse train transmitter.
package pulse_train_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_LOW_CYCLES = 4;
    localparam int DEF_GAP_CYCLES = 4;

    // Width of a down-counter that must hold values up to max(low, gap) - 1.
    // Never narrower than one bit, so a 1-cycle phase still gets a counter.
    function automatic int phase_cnt_w(input int low_c, input int gap_c);
        int m;
        m = (low_c > gap_c) ? low_c : gap_c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pulse_train_tx_phase_timer.sv
// Down-counter shared by the LOW and GAP phases. A load sets the number of
// remaining cycles minus one; expired marks the final cycle of the phase.
module phase_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    output logic [CW-1:0] value,
    output logic          expired
);

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - CW'(1);
        end
    end

    assign expired = (value == '0);

endmodule

// File: rtl/pulse_train_tx.sv
// Emits a train of active-low pulses on na: each pulse is LOW_CYCLES low
// followed by GAP_CYCLES high. All outputs are registered from the
// next-state decode so na falls on the very edge that accepts start.
module pulse_train_tx
    import pulse_train_tx_pkg::*;
#(
    parameter int WIDTH      = 2,
    parameter int LOW_CYCLES = DEF_LOW_CYCLES,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    input  logic             abort,
    output logic             na,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sent
);

    localparam int            CW       = phase_cnt_w(LOW_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] LOW_LOAD = CW'(LOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] target_n;
    logic [WIDTH-1:0] sent_n;
    logic             tmr_load;
    logic [CW-1:0]    tmr_load_value;
    logic [CW-1:0]    tmr_value;
    logic             tmr_expired;

    phase_timer #(
        .CW(CW)
    ) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .value      (tmr_value),
        .expired    (tmr_expired)
    );

    // Next-state, pulse bookkeeping and timer reload decisions.
    always_comb begin
        state_n        = state;
        target_n       = target;
        sent_n         = sent;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        case (state)
            IDLE: begin
                // abort beats start when both arrive together
                if (start && !abort) begin
                    sent_n = '0;
                    if (num != '0) begin
                        target_n       = num;
                        tmr_load       = 1'b1;
                        tmr_load_value = LOW_LOAD;
                        state_n        = LOW;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            LOW: begin
                // an aborted pulse is not counted as completed
                if (abort) begin
                    state_n = IDLE;
                end else if (tmr_expired) begin
                    sent_n         = sent + WIDTH'(1);
                    tmr_load       = 1'b1;
                    tmr_load_value = GAP_LOAD;
                    state_n        = GAP;
                end
            end
            GAP: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (tmr_expired) begin
                    if (sent == target) begin
                        state_n = DONE;
                    end else begin
                        tmr_load       = 1'b1;
                        tmr_load_value = LOW_LOAD;
                        state_n        = LOW;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            target <= '0;
            sent   <= '0;
            na     <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            target <= target_n;
            sent   <= sent_n;
            na     <= (state_n != LOW);
            busy   <= (state_n == LOW) || (state_n == GAP);
            done   <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_pulse_train_tx.sv
// Directed bench for pulse_train_tx with LOW_CYCLES = GAP_CYCLES = 4.
module tb_pulse_train_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [1:0] num;
    logic       na;
    logic       busy;
    logic       done;
    logic [1:0] sent;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       start;
        logic [1:0] num;
        logic       abort;
        logic       na;
        logic       busy;
        logic       done;
        logic [1:0] sent;
    } vec_t;

    vec_t vecs [17];

    always #5 clk = ~clk;

    pulse_train_tx #(
        .WIDTH      (2),
        .LOW_CYCLES (4),
        .GAP_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .num   (num),
        .abort (abort),
        .na    (na),
        .busy  (busy),
        .done  (done),
        .sent  (sent)
    );

    // Pulse-counting receiver: one count per completed low pulse (rising na).
    logic na_q   = 1'b1;
    logic rx_clr = 1'b0;
    int   rx_cnt = 0;
    always @(posedge clk) begin
        na_q <= na;
        if (rx_clr)
            rx_cnt <= 0;
        else if (na && !na_q)
            rx_cnt <= rx_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic e_na, input logic e_busy,
                           input logic e_done, input logic [1:0] e_sent);
        chk({tag, ".na"},   32'(na),   32'(e_na));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
        chk({tag, ".sent"}, 32'(sent), 32'(e_sent));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        num   = 2'd0;

        //         start num   abort  na    busy  done  sent
        vecs[0]  = {1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0}; // idle
        vecs[1]  = {1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0}; // num=0 -> DONE
        vecs[2]  = {1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0}; // start in DONE ignored
        vecs[3]  = {1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0}; // abort beats start
        vecs[4]  = {1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0}; // accept, na falls
        vecs[5]  = {1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0}; // num change ignored
        vecs[6]  = {1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[7]  = {1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0}; // 4th low cycle
        vecs[8]  = {1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1}; // GAP, sent=1
        vecs[9]  = {1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
        vecs[10] = {1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
        vecs[11] = {1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1}; // 4th gap cycle
        vecs[12] = {1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1}; // DONE
        vecs[13] = {1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1}; // back to IDLE
        vecs[14] = {1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0}; // second train accepted
        vecs[15] = {1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0}; // abort in LOW
        vecs[16] = {1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0}; // no done after abort

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b1, 1'b0, 1'b0, 2'd0);
        #3 reset = 1'b0;

        // Table-driven: one vector per clock edge.
        for (int i = 0; i < 17; i++) begin
            start = vecs[i].start;
            num   = vecs[i].num;
            abort = vecs[i].abort;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].na, vecs[i].busy, vecs[i].done, vecs[i].sent);
        end

        // Full 3-pulse train from reset, with the loopback receiver.
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        rx_clr = 1'b1;
        step();
        rx_clr = 1'b0;
        start = 1'b1;
        num   = 2'd3;
        step();
        start = 1'b0;
        num   = 2'd0;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) step();
            chk_out($sformatf("train3.c%0d", i),
                    (i % 8) >= 4, 1'b1, 1'b0, 2'((i / 8) + (((i % 8) >= 4) ? 1 : 0)));
        end
        step();
        chk_out("train3.done", 1'b1, 1'b0, 1'b1, 2'd3);
        step();
        chk_out("train3.idle", 1'b1, 1'b0, 1'b0, 2'd3);
        step();
        chk("loopback.rx_cnt", 32'(rx_cnt), 32'd3);
        chk("loopback.rx_vs_sent", 32'(rx_cnt), 32'(sent));

        // Abort in the second LOW cycle of pulse 2.
        start = 1'b1;
        num   = 2'd2;
        step();
        start = 1'b0;
        chk_out("abort.accept", 1'b0, 1'b1, 1'b0, 2'd0);
        repeat (8) step();
        chk_out("abort.p2low1", 1'b0, 1'b1, 1'b0, 2'd1);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_out("abort.idle", 1'b1, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("abort.quiet%0d.done", i), 32'(done), 32'd0);
            chk($sformatf("abort.quiet%0d.na", i), 32'(na), 32'd1);
        end

        // Asynchronous reset mid-LOW of pulse 2.
        start = 1'b1;
        num   = 2'd3;
        step();
        start = 1'b0;
        repeat (9) step();
        chk_out("areset.before", 1'b0, 1'b1, 1'b0, 2'd1);
        #2 reset = 1'b1;
        #1;
        chk_out("areset.during", 1'b1, 1'b0, 1'b0, 2'd0);
        #2 reset = 1'b0;
        start = 1'b1;
        num   = 2'd1;
        step();
        start = 1'b0;
        chk_out("areset.first_start", 1'b0, 1'b1, 1'b0, 2'd0);
        repeat (8) step();
        chk_out("areset.done", 1'b1, 1'b0, 1'b1, 2'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_train_tx.md
PULSE_TRAIN_TX -- requirements
Module: pulse_train_tx

Interface
REQ-001 Parameter WIDTH, default 2: width of the pulse-count request and the sent counter.
REQ-002 Parameter LOW_CYCLES, default 4: clock cycles na is held low per pulse, legal range >=1.
REQ-003 Parameter GAP_CYCLES, default 4: clock cycles na is held high after each pulse, legal range >=1.
REQ-004 clk  input  1  single system clock, rising-edge active.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to transmit num pulses, sampled only in IDLE.
REQ-007 num  input  WIDTH  number of pulses to emit, captured on the accepting edge.
REQ-008 abort  input  1  synchronous cancel of a train in progress.
REQ-009 na  output  1  active-low pulse train toward the pulse-counting receiver; idle level 1.
REQ-010 busy  output  1  high from the accepting edge until the train completes or is aborted.
REQ-011 done  output  1  single-cycle strobe after the last gap of a completed train.
REQ-012 sent  output  WIDTH  pulses fully emitted in the current or last train.

Function
REQ-013 The FSM SHALL have the states IDLE, LOW, GAP and DONE, and all outputs SHALL be registered.
REQ-014 IDLE: na=1, busy=0, done=0; when start=1 and abort=0: if num!=0, latch num into target, clear sent, load the phase counter with LOW_CYCLES-1, go to LOW; if num==0, go to DONE.
REQ-015 na SHALL fall on the same edge that accepts start (zero-cycle latency from the accept edge).
REQ-016 LOW: na=0 for exactly LOW_CYCLES cycles; on the last cycle, increment sent (wrap modulo 2^WIDTH), load GAP_CYCLES-1, go to GAP.
REQ-017 GAP: na=1 for exactly GAP_CYCLES cycles; on the last cycle, go to DONE if sent==target, else return to LOW.
REQ-018 DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE; sent holds its value until the next accepted start.
REQ-019 busy SHALL be 1 in the LOW and GAP states only.
REQ-020 start while busy or in DONE SHALL be ignored and SHALL NOT be queued.
REQ-021 abort=1 in LOW or GAP SHALL drive na=1 and the state to IDLE on the next edge, with no done strobe; sent keeps the count of pulses already completed.
REQ-022 start=1 and abort=1 together in IDLE: abort wins and no train starts.
REQ-023 Changes to num after acceptance SHALL NOT affect the train in progress.
REQ-024 The phase counter SHALL be sized to max(LOW_CYCLES, GAP_CYCLES) and SHALL NOT overflow.

Reset
REQ-025 Asserting reset SHALL immediately (asynchronously) force state=IDLE, na=1, busy=0, done=0, sent=0 and clear the phase counter, including mid-pulse.
REQ-026 After reset deasserts, the first start SHALL be accepted on the first rising edge at which it is high.

Structure
REQ-027 A shared package SHALL hold the FSM state enum type (IDLE, LOW, GAP, DONE) and the default LOW_CYCLES and GAP_CYCLES constants.
REQ-028 One sub-module, phase_timer (load, value, expired), SHALL implement the down-counter shared by the LOW and GAP phases.

Verification
REQ-029 Scenario 1: reset, then start=1 with num=3 for one cycle (LOW=4, GAP=4) -> three na-low windows of 4 cycles separated by 4-cycle highs; busy high for 24 cycles; done for 1 cycle; sent=3.
REQ-030 Scenario 2: start with num=0 -> na stays 1, busy stays 0, done pulses on the next cycle, sent=0.
REQ-031 Scenario 3: num=2, assert abort in the second LOW cycle of pulse 2 -> na returns to 1 at the next edge, no done, sent=1.
REQ-032 Scenario 4: num=1, hold start high for the whole train -> exactly one pulse and one done, then a second train is accepted in IDLE after DONE.
REQ-033 Scenario 5: assert reset asynchronously mid-LOW during num=3 -> na=1 and sent=0 without waiting for a clock edge.
REQ-034 Scenario 6: loopback of na into the pulse-counting receiver with num=3 -> receiver count advances 0 to 3, matching sent.
